mem_port_arbiter: RTL

//  Two-port round-robin arbiter/sequencer in front of the single-ported Memory (request/rw/wait_ handshake).

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported request/rw/wait_ memory.
// Port 0 is read-only instruction fetch, port 1 is data load/store; every output is registered.
module mem_port_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_done,
  input  logic          p1_req,
  input  logic          p1_rw,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_request,
  output logic          mem_rw,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_wait_,
  output logic          busy,
  output logic          grant_id
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CountMax = CW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StAccess, StRelease} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  logic          rw_q, rw_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic          p0_done_q, p0_done_d;
  logic          p1_done_q, p1_done_d;
  logic          err_q, err_d;
  logic          grant_q, grant_d;
  logic          rr_q, rr_d;
  logic          busy_q;
  logic [CW-1:0] count_q, count_d;
  logic          sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      req_q      <= 1'b0;
      rw_q       <= 1'b1;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      err_q      <= 1'b0;
      grant_q    <= 1'b0;
      rr_q       <= 1'b1;
      busy_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      p0_done_q  <= p0_done_d;
      p1_done_q  <= p1_done_d;
      err_q      <= err_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      busy_q     <= (state_d != StIdle);
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_d      = req_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    p0_done_d  = 1'b0;
    p1_done_d  = 1'b0;
    err_d      = 1'b0;
    grant_d    = grant_q;
    rr_d       = rr_q;
    count_d    = count_q;
    sel        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (p0_req || p1_req) begin
          // Only a tie consults and advances the round-robin pointer.
          sel = (p0_req && p1_req) ? rr_q : p1_req;
          if (p0_req && p1_req) begin
            rr_d = ~sel;
          end
          addr_d = sel ? p1_addr : p0_addr;
          rw_d   = sel ? p1_rw : 1'b1;
          if (sel) begin
            wdata_d = p1_wdata;
          end
          req_d   = 1'b1;
          grant_d = sel;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (!mem_wait_) begin
          if (rw_q) begin
            if (grant_q) begin
              p1_rdata_d = mem_rdata;
            end else begin
              p0_rdata_d = mem_rdata;
            end
          end
          p0_done_d = ~grant_q;
          p1_done_d = grant_q;
          req_d     = 1'b0;
          rw_d      = 1'b1;
          state_d   = StRelease;
        end else begin
          count_d = count_q + CW'(1);
          if (count_d == CountMax) begin
            p0_done_d = ~grant_q;
            p1_done_d = grant_q;
            err_d     = 1'b1;
            req_d     = 1'b0;
            rw_d      = 1'b1;
            state_d   = StRelease;
          end
        end
      end
      StRelease: begin
        // Memory must deassert completion before the bus is reused.
        if (mem_wait_) begin
          state_d = StIdle;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_addr    = addr_q;
  assign mem_request = req_q;
  assign mem_rw      = rw_q;
  assign mem_wdata   = wdata_q;
  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;
  assign p0_done     = p0_done_q;
  assign p1_done     = p1_done_q;
  assign err         = err_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;

endmodule
